// File: rtl/mdio_pkg.sv
// Shared types and field widths for the Clause 22 MDIO responder.
// Optional build macro: MDIO_RESPONDER_PREAMBLE_SUPPRESSION_EN.
package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ST,
        OP,
        PHYAD,
        REGAD,
        TA,
        RD_DATA,
        WR_DATA
    } mdio_state_t;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam int PREAMBLE_LEN = 32;
    localparam int ADDR_W       = 5;
    localparam int DATA_W       = 16;

endpackage

// File: rtl/mdio_sync.sv
// Brings MDC and MDIO into the sys_clk domain and flags MDC rising edges.
// MDIO shares the same synchronizer depth, so it lines up with the edge strobe.
module mdio_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_mdc,
    input  logic i_mdio,
    output logic o_mdc_rise,
    output logic o_mdio
);

    logic [1:0] r_mdc_sync;
    logic [1:0] r_mdio_sync;
    logic       r_mdc_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mdc_sync  <= 2'b00;
            r_mdio_sync <= 2'b11;
            r_mdc_prev  <= 1'b0;
        end else begin
            r_mdc_sync  <= {r_mdc_sync[0], i_mdc};
            r_mdio_sync <= {r_mdio_sync[0], i_mdio};
            r_mdc_prev  <= r_mdc_sync[1];
        end
    end

    assign o_mdc_rise = r_mdc_sync[1] & ~r_mdc_prev;
    assign o_mdio     = r_mdio_sync[1];

endmodule

// File: rtl/mdio_responder.sv
// Clause 22 MDIO responder: frame decoder, small register file, read driver.
// Optional build macro: MDIO_RESPONDER_PREAMBLE_SUPPRESSION_EN (short/absent preamble).
//
// state   | meaning
// IDLE    | counting preamble ones, waiting for the ST 0 bit
// ST      | expecting the ST 1 bit
// OP      | collecting the 2 opcode bits
// PHYAD   | collecting the 5 PHY address bits
// REGAD   | collecting the 5 register address bits
// TA      | turnaround; a matching read starts driving on the 2nd bit
// RD_DATA | shifting out 16 read data bits (or idling through them)
// WR_DATA | collecting 16 write data bits
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PHY_ADDR = 5'd1,
    parameter logic [DATA_W-1:0] PHY_ID1  = 16'h0022,
    parameter logic [DATA_W-1:0] PHY_ID2  = 16'h1622
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              mdc,
    input  logic              mdio_i,
    output logic              mdio_o,
    output logic              mdio_t,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    logic              w_rise;
    logic              w_mdio;
    logic              w_pre_ok;
    logic              w_frame_end;
    logic              w_wr_fire;
    logic [1:0]        w_op;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_wr_word;
    mdio_state_t       w_next;

    mdio_state_t       r_state;
    logic [4:0]        r_bit_cnt;
    logic [5:0]        r_pre_cnt;
    logic [1:0]        r_op;
    logic [3:0]        r_phyad;
    logic [ADDR_W-1:0] r_regad;
    logic [DATA_W-1:0] r_shift;
    logic              r_match;
    logic [DATA_W-1:0] r_regs [16];
`ifdef MDIO_RESPONDER_PREAMBLE_SUPPRESSION_EN
    logic              r_after_frame;
`endif

    mdio_sync u_sync (
        .i_clk      (sys_clk),
        .i_rst      (rst),
        .i_mdc      (mdc),
        .i_mdio     (mdio_i),
        .o_mdc_rise (w_rise),
        .o_mdio     (w_mdio)
    );

`ifdef MDIO_RESPONDER_PREAMBLE_SUPPRESSION_EN
    assign w_pre_ok = (r_pre_cnt != 6'd0) || r_after_frame;
`else
    assign w_pre_ok = (r_pre_cnt >= 6'(PREAMBLE_LEN));
`endif

    assign w_op        = {r_op[0], w_mdio};
    assign w_wr_word   = {r_shift[DATA_W-2:0], w_mdio};
    assign w_frame_end = w_rise && (r_state == RD_DATA || r_state == WR_DATA)
                         && (r_bit_cnt == 5'd15);
    // Registers 2/3 are the read-only IDs and 16-31 are unimplemented.
    assign w_wr_fire   = w_frame_end && (r_state == WR_DATA) && r_match
                         && !r_regad[4] && (r_regad[3:1] != 3'b001);

    always_comb begin
        w_rd_data = '0;
        if (r_regad == 5'd2)
            w_rd_data = PHY_ID1;
        else if (r_regad == 5'd3)
            w_rd_data = PHY_ID2;
        else if (!r_regad[4])
            w_rd_data = r_regs[r_regad[3:0]];
    end

    always_comb begin
        w_next = r_state;
        if (w_rise) begin
            case (r_state)
                IDLE:    if (!w_mdio && w_pre_ok) w_next = ST;
                ST:      w_next = w_mdio ? OP : IDLE;
                OP:      if (r_bit_cnt == 5'd1)
                             w_next = (w_op == OP_READ || w_op == OP_WRITE) ? PHYAD : IDLE;
                PHYAD:   if (r_bit_cnt == 5'd4) w_next = REGAD;
                REGAD:   if (r_bit_cnt == 5'd4) w_next = TA;
                TA:      if (r_bit_cnt == 5'd1)
                             w_next = (r_op == OP_READ) ? RD_DATA : WR_DATA;
                RD_DATA: if (r_bit_cnt == 5'd15) w_next = IDLE;
                WR_DATA: if (r_bit_cnt == 5'd15) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_pre_cnt <= '0;
            r_op      <= '0;
            r_phyad   <= '0;
            r_regad   <= '0;
            r_shift   <= '0;
            r_match   <= 1'b0;
            mdio_o    <= 1'b0;
            mdio_t    <= 1'b1;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
`ifdef MDIO_RESPONDER_PREAMBLE_SUPPRESSION_EN
            r_after_frame <= 1'b0;
`endif
        end else begin
            wr_valid <= 1'b0;
            if (w_rise) begin
                r_state   <= w_next;
                r_bit_cnt <= (w_next != r_state || r_state == IDLE) ? 5'd0 : r_bit_cnt + 5'd1;
                case (r_state)
                    IDLE: begin
                        if (!w_mdio)
                            r_pre_cnt <= '0;
                        else if (r_pre_cnt != 6'h3F)
                            r_pre_cnt <= r_pre_cnt + 6'd1;
                    end
                    OP:    r_op    <= w_op;
                    PHYAD: begin
                        r_phyad <= {r_phyad[2:0], w_mdio};
                        if (r_bit_cnt == 5'd4)
                            r_match <= ({r_phyad, w_mdio} == PHY_ADDR);
                    end
                    REGAD: r_regad <= {r_regad[3:0], w_mdio};
                    TA: begin
                        if (r_op == OP_READ && r_match) begin
                            if (r_bit_cnt == 5'd0) begin
                                mdio_t <= 1'b0;
                                mdio_o <= 1'b0;
                            end else begin
                                mdio_o  <= w_rd_data[DATA_W-1];
                                r_shift <= {w_rd_data[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                    RD_DATA: begin
                        if (r_bit_cnt == 5'd15) begin
                            mdio_t <= 1'b1;
                            mdio_o <= 1'b0;
                        end else begin
                            mdio_o  <= r_shift[DATA_W-1];
                            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                    WR_DATA: begin
                        r_shift <= w_wr_word;
                        if (r_bit_cnt == 5'd15 && r_match) begin
                            wr_valid <= 1'b1;
                            wr_addr  <= r_regad;
                            wr_data  <= w_wr_word;
                        end
                    end
                    default: ;
                endcase
`ifdef MDIO_RESPONDER_PREAMBLE_SUPPRESSION_EN
                if (w_frame_end)
                    r_after_frame <= 1'b1;
                else if (w_next == ST)
                    r_after_frame <= 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++)
                r_regs[i] <= '0;
        end else if (w_wr_fire) begin
            r_regs[r_regad[3:0]] <= w_wr_word;
        end
    end

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: directed frame table, mid-frame reset, random frames.
// Honours MDIO_RESPONDER_PREAMBLE_SUPPRESSION_EN the same way as the design.
module tb_mdio_responder;

    localparam logic [1:0] RD = 2'b10;
    localparam logic [1:0] WR = 2'b01;

    logic        sys_clk;
    logic        rst;
    logic        mdc;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_t;
    logic        wr_valid;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;

    int n_cmp  = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    logic [4:0]  wr_last_a;
    logic [15:0] wr_last_d;
    logic [15:0] m_regs [32];

    mdio_responder dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .mdc      (mdc),
        .mdio_i   (mdio_i),
        .mdio_o   (mdio_o),
        .mdio_t   (mdio_t),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (wr_valid) begin
            wr_cnt    = wr_cnt + 1;
            wr_last_a = wr_addr;
            wr_last_d = wr_data;
        end
    end

    typedef struct {
        int          pre;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  ra;
        logic [15:0] wd;
        bit          exp_resp;
        logic [15:0] exp_rd;
        string       nm;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [4:0] a);
        if (a == 5'd2) return 16'h0022;
        if (a == 5'd3) return 16'h1622;
        if (a >= 5'd16) return 16'h0000;
        return m_regs[a];
    endfunction

    task automatic m_write(input logic [4:0] a, input logic [15:0] d);
        if (a < 5'd16 && a != 5'd2 && a != 5'd3)
            m_regs[a] = d;
    endtask

    task automatic m_clear();
        for (int i = 0; i < 32; i++)
            m_regs[i] = 16'h0000;
    endtask

    // One station-side frame; bit k's responder drive is sampled just before the MDC edge ending bit k.
    task automatic do_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] ra, input logic [15:0] wd, input bit exp_resp,
                            input logic [15:0] exp_rd, input string nm, input int rst_at);
        logic bq[$];
        logic t_s[128];
        logic o_s[128];
        logic t_after;
        logic [15:0] got;
        int n_hdr, t_err, wr0, exp_w;
        bit rd;

        repeat (pre) bq.push_back(1'b1);
        bq.push_back(1'b0);
        bq.push_back(1'b1);
        bq.push_back(op[1]);
        bq.push_back(op[0]);
        for (int i = 4; i >= 0; i--) bq.push_back(phy[i]);
        for (int i = 4; i >= 0; i--) bq.push_back(ra[i]);
        n_hdr = pre + 14;
        if (op == WR) begin
            bq.push_back(1'b1);
            bq.push_back(1'b0);
            for (int i = 15; i >= 0; i--) bq.push_back(wd[i]);
        end else begin
            repeat (18) bq.push_back(1'b1);
        end

        wr0 = wr_cnt;
        for (int i = 0; i < bq.size(); i++) begin
            mdc    = 1'b0;
            mdio_i = bq[i];
            if (i == rst_at) begin
                #20;
                chk({nm, " driving before rst"}, 32'(mdio_t), 32'd0);
                rst = 1'b1;
                #1;
                chk({nm, " mdio_t on rst"}, 32'(mdio_t), 32'd1);
                chk({nm, " mdio_o on rst"}, 32'(mdio_o), 32'd0);
                #9;
                rst = 1'b0;
                #20;
                chk({nm, " no partial write"}, 32'(wr_cnt - wr0), 32'd0);
                mdio_i = 1'b1;
                return;
            end
            #40;
            t_s[i] = mdio_t;
            o_s[i] = mdio_o;
            mdc    = 1'b1;
            #40;
        end
        t_after = mdio_t;

        rd    = exp_resp && (op == RD);
        t_err = 0;
        for (int i = 0; i < bq.size(); i++)
            if (t_s[i] !== !(rd && i >= n_hdr + 1)) t_err++;
        chk({nm, " mdio_t pattern errors"}, 32'(t_err), 32'd0);
        chk({nm, " released after frame"}, 32'(t_after), 32'd1);
        if (rd) begin
            chk({nm, " TA bit 2 value"}, 32'(o_s[n_hdr + 1]), 32'd0);
            for (int j = 0; j < 16; j++) got[15 - j] = o_s[n_hdr + 2 + j];
            chk({nm, " read data"}, 32'(got), 32'(exp_rd));
        end
        exp_w = (exp_resp && op == WR) ? 1 : 0;
        chk({nm, " wr_valid pulses"}, 32'(wr_cnt - wr0), 32'(exp_w));
        if (exp_w == 1 && wr_cnt - wr0 == 1) begin
            chk({nm, " wr_addr"}, 32'(wr_last_a), 32'(ra));
            chk({nm, " wr_data"}, 32'(wr_last_d), 32'(wd));
            m_write(ra, wd);
        end
        mdio_i = 1'b1;
    endtask

    vec_t tbl[$];

    initial begin
`ifdef MDIO_RESPONDER_PREAMBLE_SUPPRESSION_EN
        bit sup = 1'b1;
`else
        bit sup = 1'b0;
`endif
        tbl.push_back('{32, WR, 5'd1, 5'd4,  16'hA5C3, 1'b1, 16'h0000, "wr r4"});
        tbl.push_back('{32, RD, 5'd1, 5'd4,  16'h0000, 1'b1, 16'hA5C3, "rd r4"});
        tbl.push_back('{32, RD, 5'd1, 5'd2,  16'h0000, 1'b1, 16'h0022, "rd id1"});
        tbl.push_back('{32, RD, 5'd1, 5'd3,  16'h0000, 1'b1, 16'h1622, "rd id2"});
        tbl.push_back('{32, RD, 5'd1, 5'd20, 16'h0000, 1'b1, 16'h0000, "rd r20"});
        tbl.push_back('{32, RD, 5'd7, 5'd4,  16'h0000, 1'b0, 16'h0000, "rd phy7"});
        tbl.push_back('{32, WR, 5'd7, 5'd5,  16'h1234, 1'b0, 16'h0000, "wr phy7"});
        tbl.push_back('{32, WR, 5'd1, 5'd0,  16'h0F0F, 1'b1, 16'h0000, "wr r0"});
        tbl.push_back('{31, WR, 5'd1, 5'd5,  16'hBEEF, sup,  16'h0000, "wr pre31"});
        tbl.push_back('{32, RD, 5'd1, 5'd5,  16'h0000, 1'b1, sup ? 16'hBEEF : 16'h0000, "rd r5"});
        tbl.push_back('{0,  RD, 5'd1, 5'd4,  16'h0000, sup,  16'hA5C3, "rd pre0"});
        tbl.push_back('{34, WR, 5'd1, 5'd2,  16'h1111, 1'b1, 16'h0000, "wr id1"});
        tbl.push_back('{32, RD, 5'd1, 5'd2,  16'h0000, 1'b1, 16'h0022, "rd id1 again"});
        tbl.push_back('{32, WR, 5'd1, 5'd31, 16'hFFFF, 1'b1, 16'h0000, "wr r31"});
        tbl.push_back('{32, RD, 5'd1, 5'd31, 16'h0000, 1'b1, 16'h0000, "rd r31"});
        tbl.push_back('{32, WR, 5'd1, 5'd15, 16'h8001, 1'b1, 16'h0000, "wr r15"});
        tbl.push_back('{33, RD, 5'd1, 5'd15, 16'h0000, 1'b1, 16'h8001, "rd r15"});
        tbl.push_back('{32, RD, 5'd1, 5'd0,  16'h0000, 1'b1, 16'h0F0F, "rd r0"});

        m_clear();
        rst    = 1'b1;
        mdc    = 1'b0;
        mdio_i = 1'b1;
        #30;
        chk("reset mdio_t", 32'(mdio_t), 32'd1);
        chk("reset mdio_o", 32'(mdio_o), 32'd0);
        chk("reset wr_valid", 32'(wr_valid), 32'd0);
        chk("reset wr_addr", 32'(wr_addr), 32'd0);
        chk("reset wr_data", 32'(wr_data), 32'd0);
        rst = 1'b0;
        #40;

        foreach (tbl[k])
            do_frame(tbl[k].pre, tbl[k].op, tbl[k].phy, tbl[k].ra, tbl[k].wd,
                     tbl[k].exp_resp, tbl[k].exp_rd, tbl[k].nm, -1);

        // Reset lands while data bit 8 (bit 15-8=7 of the word) is on the wire.
        do_frame(32, RD, 5'd1, 5'd4, 16'h0000, 1'b1, 16'hA5C3, "rst mid read", 32 + 14 + 2 + 8);
        m_clear();
        #80;
        do_frame(32, RD, 5'd1, 5'd4, 16'h0000, 1'b1, 16'h0000, "rd r4 after rst", -1);
        do_frame(32, WR, 5'd1, 5'd4, 16'h1357, 1'b1, 16'h0000, "wr r4 after rst", -1);
        do_frame(32, RD, 5'd1, 5'd4, 16'h0000, 1'b1, 16'h1357, "rd r4 after wr", -1);

        for (int k = 0; k < 24; k++) begin
            logic [1:0]  op;
            logic [4:0]  phy;
            logic [4:0]  ra;
            logic [15:0] wd;
            op  = ($urandom_range(0, 1) == 0) ? RD : WR;
            phy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd1;
            ra  = 5'($urandom_range(0, 31));
            wd  = 16'($urandom);
            do_frame($urandom_range(32, 36), op, phy, ra, wd, phy == 5'd1, m_read(ra),
                     $sformatf("rand%0d", k), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
